// File: rtl/spi_host_fifo.sv
// Host-side TX/RX byte FIFOs in front of an SPI core, with a sequencer that moves one
// byte at a time: load TX head, wait for the core to accept it, wait for the reply, read it back.
module spi_host_fifo #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       HOST_WR,
  input  logic [7:0] HOST_D,
  input  logic       HOST_RD,
  output logic [7:0] HOST_Q,
  output logic       TX_FULL,
  output logic       RX_EMPTY,
  output logic       OVF,
  output logic       ERR,
  output logic       SPI_WRITE,
  output logic       SPI_READ,
  output logic [7:0] SPI_DATA_O,
  input  logic [7:0] SPI_DATA_I,
  input  logic       SPI_TX_EMPTY,
  input  logic       SPI_RX_FULL,
  output logic [2:0] DBG_STATE
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_ACK, S_WAIT_DONE, S_READ, S_CAPT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      tx_mem_q [DEPTH];
  logic [7:0]      rx_mem_q [DEPTH];
  logic [AW-1:0]   tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [AW:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      data_o_q, host_q_q, host_q_d;
  logic            ovf_q, err_q;
  logic            tx_push, tx_pop, rx_push, rx_pop, err_set, load_next;
  logic            tx_full, tx_empty, rx_full, rx_empty;

  assign tx_full  = (tx_cnt_q == CNT_FULL);
  assign tx_empty = (tx_cnt_q == CNT_ZERO);
  assign rx_full  = (rx_cnt_q == CNT_FULL);
  assign rx_empty = (rx_cnt_q == CNT_ZERO);

  // A push into a full TX FIFO is still accepted when the sequencer pops in the same cycle.
  assign tx_push   = HOST_WR && (!tx_full || tx_pop);
  assign rx_pop    = HOST_RD && !rx_empty;
  assign load_next = (state_q == S_IDLE) && (state_d == S_LOAD);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // HOST_Q tracks the RX head: next entry on a pop, incoming byte when RX was (or becomes) empty.
  always_comb begin
    host_q_d = host_q_q;
    if (rx_pop) begin
      if (rx_cnt_q > CNT_ONE)  host_q_d = rx_mem_q[rx_rp_q + PTR_ONE];
      else if (rx_push)        host_q_d = SPI_DATA_I;
    end else if (rx_push && rx_empty) begin
      host_q_d = SPI_DATA_I;
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= HOST_D;
    if (rx_push) rx_mem_q[rx_wp_q] <= SPI_DATA_I;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      host_q_q <= 8'h00;
      data_o_q <= 8'h00;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      tmr_q    <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PTR_ONE;
      if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_ONE;
      if (rx_push) rx_wp_q <= rx_wp_q + PTR_ONE;
      if (rx_pop)  rx_rp_q <= rx_rp_q + PTR_ONE;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      host_q_q <= host_q_d;
      if (load_next)               data_o_q <= tx_mem_q[tx_rp_q];
      if (HOST_WR && !tx_push)     ovf_q    <= 1'b1;
      if (err_set)                 err_q    <= 1'b1;
      tmr_q <= tmr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!tx_empty && SPI_TX_EMPTY) state_d = S_LOAD;
      S_LOAD:      state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (!SPI_TX_EMPTY)          state_d = S_WAIT_DONE;
                   else if (tmr_q == TMR_LAST) state_d = S_IDLE;
      S_WAIT_DONE: if (SPI_RX_FULL) begin
                     if (!rx_full) state_d = S_READ;
                   end else if (tmr_q == TMR_LAST) begin
                     state_d = S_IDLE;
                   end
      S_READ:      state_d = S_CAPT;
      S_CAPT:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Timer restarts on every state change and is frozen while a reply waits on a full RX FIFO.
  always_comb begin
    SPI_WRITE = (state_q == S_LOAD);
    SPI_READ  = (state_q == S_READ);
    tx_pop    = (state_q == S_LOAD);
    rx_push   = (state_q == S_CAPT);
    err_set   = (tmr_q == TMR_LAST) &&
                (((state_q == S_WAIT_ACK) && SPI_TX_EMPTY) ||
                 ((state_q == S_WAIT_DONE) && !SPI_RX_FULL));
    tmr_d     = tmr_q;
    if (state_d != state_q)
      tmr_d = '0;
    else if ((state_q == S_WAIT_ACK) || ((state_q == S_WAIT_DONE) && !SPI_RX_FULL))
      tmr_d = tmr_q + TMR_ONE;
  end

  assign HOST_Q     = host_q_q;
  assign TX_FULL    = tx_full;
  assign RX_EMPTY   = rx_empty;
  assign OVF        = ovf_q;
  assign ERR        = err_q;
  assign SPI_DATA_O = data_o_q;
  assign DBG_STATE  = state_q;

endmodule
